// File: rtl/osecpu_pkg.sv
// Shared definitions for the OSECPU run/debug sequencer: FSM state encoding
// and the core program-counter width.
package osecpu_pkg;

    localparam int OSECPU_PC_W = 16;

    typedef enum logic [1:0] {
        ST_RSTH = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_e;

endpackage

// File: rtl/osecpu_run_ctrl.sv
// Run/halt/step/breakpoint sequencer owning the OSECPU core reset and clock enable.
// Optional enabled-cycle counter output cyc_cnt when OSECPU_RUN_CTRL_CYCCNT_EN is defined.
module osecpu_run_ctrl
    import osecpu_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int STEP_TMO   = 64,
    parameter bit AUTORUN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_req,
    input  logic                   halt_req,
    input  logic                   step_req,
    input  logic                   rst_req,
    input  logic                   bp_en,
    input  logic [OSECPU_PC_W-1:0] bp_addr,
    input  logic [OSECPU_PC_W-1:0] osecpu_pc,
    output logic                   cpu_reset,
    output logic                   cpu_en,
    output logic                   halted,
    output logic [1:0]             state,
    output logic                   step_tmo
`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
    ,
    output logic [31:0]            cyc_cnt
`endif
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int TMO_W  = $clog2(STEP_TMO + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(STEP_TMO - 1);

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [OSECPU_PC_W-1:0] pc_q, pc_d;
    logic                   bp_skip_q, bp_skip_d;
    logic                   step_tmo_q, step_tmo_d;
    logic                   cpu_reset_q, halted_q;
    logic                   bp_hit, pc_moved;

    assign bp_hit   = bp_en && (osecpu_pc == bp_addr) && !bp_skip_q;
    assign pc_moved = (osecpu_pc != pc_q);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tmo_d      = tmo_q;
        pc_d       = pc_q;
        bp_skip_d  = bp_skip_q;
        step_tmo_d = step_tmo_q;
        cpu_en     = 1'b0;

        // Skip only masks the breakpoint until the core has moved off it.
        if (bp_skip_q && pc_moved) begin
            bp_skip_d = 1'b0;
        end

        unique case (state_q)
            ST_RSTH: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = AUTORUN ? ST_RUN : ST_HALT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                cpu_en = !bp_hit;
                if (halt_req || bp_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!halt_req && (step_req || run_req)) begin
                    state_d   = step_req ? ST_STEP : ST_RUN;
                    pc_d      = osecpu_pc;
                    bp_skip_d = (osecpu_pc == bp_addr);
                    tmo_d     = '0;
                end
            end
            ST_STEP: begin
                cpu_en = !pc_moved;
                if (halt_req || pc_moved) begin
                    state_d = ST_HALT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = ST_HALT;
                    step_tmo_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase

        if (run_req) begin
            step_tmo_d = 1'b0;
        end

        if (rst_req) begin
            state_d    = ST_RSTH;
            hold_d     = '0;
            bp_skip_d  = 1'b0;
            step_tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RSTH;
            hold_q      <= '0;
            tmo_q       <= '0;
            pc_q        <= '0;
            bp_skip_q   <= 1'b0;
            step_tmo_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            pc_q        <= pc_d;
            bp_skip_q   <= bp_skip_d;
            step_tmo_q  <= step_tmo_d;
            cpu_reset_q <= (state_d == ST_RSTH);
            halted_q    <= (state_d == ST_HALT);
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign halted    = halted_q;
    assign state     = state_q;
    assign step_tmo  = step_tmo_q;

`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
    logic [31:0] cyc_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_d == ST_RSTH)) begin
            cyc_cnt_q <= '0;
        end else if (cpu_en) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_osecpu_run_ctrl.sv
// Directed bench for osecpu_run_ctrl with a looping-PC core model (0..11) and a freeze stub.
`timescale 1ns/1ps
module tb_osecpu_run_ctrl;
    import osecpu_pkg::*;

    localparam int LOOP = 12;

    logic        clk = 1'b0;
    logic        reset, run_req, halt_req, step_req, rst_req, bp_en, freeze;
    logic [15:0] bp_addr;
    logic [15:0] pc_m = 16'd0;
    logic        cpu_reset, cpu_en, halted, step_tmo;
    logic [1:0]  state;
`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] c0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n, k, exp_pc;

    typedef struct packed {
        logic       rst, halt, step, run;
        logic [1:0] st;
        logic       hlt, crst;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    osecpu_run_ctrl #(.RST_CYCLES(16), .STEP_TMO(64), .AUTORUN(1'b1)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .rst_req(rst_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .osecpu_pc(pc_m), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .halted(halted),
        .state(state), .step_tmo(step_tmo)
`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
        , .cyc_cnt(cyc_cnt)
`endif
    );

    // Core model: counts 0..LOOP-1 and wraps while enabled, unless frozen.
    always @(posedge clk) begin
        if (cpu_reset) pc_m <= 16'd0;
        else if (cpu_en && !freeze) pc_m <= (pc_m == 16'(LOOP - 1)) ? 16'd0 : pc_m + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic pulse(input logic r, input logic h, input logic s, input logic g);
        rst_req = r; halt_req = h; step_req = s; run_req = g;
        tick();
        rst_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    endtask

    task automatic wait_halted(input int max, output int cnt);
        cnt = 0;
        while (!halted && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_reset_release(output int cnt);
        cnt = 0;
        while (cpu_reset && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst   halt  step  run   state    hlt   crst
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_RUN,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, ST_HALT, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_STEP, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_HALT, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, ST_RSTH, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_RSTH, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, ST_RSTH, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_RSTH, 1'b0, 1'b1};

        reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; rst_req = 1'b0;
        bp_en = 1'b0; bp_addr = 16'd0; freeze = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(state), 32'(ST_RSTH));
        check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_step_tmo", 32'(step_tmo), 32'd0);
        check("reset_cpu_en", 32'(cpu_en), 32'd0);

        // Power-up hold then autorun.
        reset = 1'b0;
        wait_reset_release(n);
        check("rst_hold_cycles", 32'(n), 32'd16);
        check("autorun_state", 32'(state), 32'(ST_RUN));
        check("autorun_cpu_en", 32'(cpu_en), 32'd1);

        // Breakpoint at 6.
        bp_addr = 16'd6; bp_en = 1'b1;
        n = 0;
        while (cpu_en && n < 40) begin tick(); n++; end
        check("bp_drop_pc", 32'(pc_m), 32'd6);
        check("bp_drop_state", 32'(state), 32'(ST_RUN));
        tick();
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_pc_held", 32'(pc_m), 32'd6);
        repeat (3) tick();
        check("bp_pc_still", 32'(pc_m), 32'd6);

        // Single step off the breakpoint.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("step_state", 32'(state), 32'(ST_STEP));
        wait_halted(20, n);
        check("step_cycles", 32'(n), 32'd2);
        check("step_pc", 32'(pc_m), 32'd7);
        check("step_tmo_clear", 32'(step_tmo), 32'd0);
        repeat (2) tick();
        check("step_pc_held", 32'(pc_m), 32'd7);

        // Run from 7 until the loop comes back to 6.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_halted(40, n);
        check("rerun_cycles", 32'(n), 32'd12);
        check("rerun_pc", 32'(pc_m), 32'd6);

        // Run from sitting on the breakpoint: must skip it once and loop around.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("skip_state", 32'(state), 32'(ST_RUN));
        check("skip_cpu_en", 32'(cpu_en), 32'd1);
        wait_halted(40, n);
        check("skip_loop_cycles", 32'(n), 32'd13);
        check("skip_pc", 32'(pc_m), 32'd6);

        // halt_req in RUN lets the core advance exactly once.
        bp_en = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        exp_pc = (int'(pc_m) + 1) % LOOP;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_state", 32'(state), 32'(ST_HALT));
        check("halt_pc_plus1", 32'(pc_m), 32'(exp_pc));
        tick();
        check("halt_pc_frozen", 32'(pc_m), 32'(exp_pc));

        // Request priority table, one cycle per vector, starting from RUN.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].rst, vecs[i].halt, vecs[i].step, vecs[i].run);
            check($sformatf("prio_v%0d", i), 32'({state, halted, cpu_reset}),
                  32'({vecs[i].st, vecs[i].hlt, vecs[i].crst}));
        end
`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
        check("cyccnt_after_rst", cyc_cnt, 32'd0);
`endif
        wait_reset_release(n);
        check("rstreq_hold_cycles", 32'(n), 32'd16);
        check("rstreq_state", 32'(state), 32'(ST_RUN));

        // Step timeout with the core stuck on one PC.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        freeze = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n = 0; k = 0;
        while (state == ST_STEP && k < 200) begin
            if (cpu_en) n++;
            tick();
            k++;
        end
        check("tmo_enable_cycles", 32'(n), 32'd64);
        check("tmo_state", 32'(state), 32'(ST_HALT));
        check("tmo_flag", 32'(step_tmo), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("tmo_cleared_by_run", 32'(step_tmo), 32'd0);
        check("tmo_run_state", 32'(state), 32'(ST_RUN));

        // halt_req aborts a step in progress.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_state", 32'(state), 32'(ST_HALT));
        check("abort_no_tmo", 32'(step_tmo), 32'd0);
        freeze = 1'b0;

`ifdef OSECPU_RUN_CTRL_CYCCNT_EN
        c0 = cyc_cnt;
        repeat (3) tick();
        check("cyccnt_frozen", cyc_cnt, c0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (100) tick();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("cyccnt_run101", cyc_cnt, c0 + 32'd101);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("cyccnt_cleared", cyc_cnt, 32'd0);
        wait_reset_release(n);
`endif

        // Reset while running returns to reset values immediately.
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun_reset_state", 32'(state), 32'(ST_RSTH));
        check("midrun_reset_cpu_reset", 32'(cpu_reset), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
